// File: rtl/fmap_reader_pkg.sv
// Shared types and constants for the feature-map read-back path.
// Region bases and byte geometry match the layer write-back side.
package fmap_reader_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned BYTES_PER_WORD = 8;
   localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
   localparam int unsigned REGION_A_BASE  = 0;
   localparam int unsigned REGION_B_BASE  = 128;

   typedef enum logic [2:0] {
      FR_IDLE = 3'd0,
      FR_REQ  = 3'd1,
      FR_WAIT = 3'd2,
      FR_EMIT = 3'd3,
      FR_DONE = 3'd4
   } fr_state_e;

   // Negative bytes clamp to zero.
   function automatic logic [BYTE_W-1:0] fr_relu(input logic [BYTE_W-1:0] b);
      return b[BYTE_W-1] ? '0 : b;
   endfunction

endpackage

// File: rtl/fmap_reader_if.sv
// Control, BRAM read port and byte-stream bundle of fmap_reader.
// master = controller/BRAM/consumer side, slave = the reader itself.
interface fmap_reader_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 8
);
   logic              start;
   logic [ADDR_W-1:0] base_addr_1;
   logic [ADDR_W-1:0] base_addr_2;
   logic [CNT_W-1:0]  word_cnt;
   logic              en_BRAM32k;
   logic [ADDR_W-1:0] addr_BRAM32k_1;
   logic [ADDR_W-1:0] addr_BRAM32k_2;
   logic [DATA_W-1:0] dout_BRAM32k_1;
   logic [DATA_W-1:0] dout_BRAM32k_2;
   logic [7:0]        byte_a;
   logic [7:0]        byte_b;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;

   modport master (
      output start, base_addr_1, base_addr_2, word_cnt,
      output dout_BRAM32k_1, dout_BRAM32k_2, out_ready,
      input  en_BRAM32k, addr_BRAM32k_1, addr_BRAM32k_2,
      input  byte_a, byte_b, out_valid, busy, done
   );

   modport slave (
      input  start, base_addr_1, base_addr_2, word_cnt,
      input  dout_BRAM32k_1, dout_BRAM32k_2, out_ready,
      output en_BRAM32k, addr_BRAM32k_1, addr_BRAM32k_2,
      output byte_a, byte_b, out_valid, busy, done
   );
endinterface

// File: rtl/fmap_unpack_lane.sv
// One unpack lane: loads a packed BRAM word and presents its bytes MSB-first,
// shifting one byte per accepted handshake.
module fmap_unpack_lane
   import fmap_reader_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [DATA_W-1:0] i_data,
   output logic [BYTE_W-1:0] o_byte
);
   logic [DATA_W-1:0] r_shreg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shreg <= '0;
      end else if (i_load) begin
         r_shreg <= i_data;
      end else if (i_shift) begin
         r_shreg <= {r_shreg[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      end
   end

   assign o_byte = r_shreg[DATA_W-1 -: BYTE_W];
endmodule

// File: rtl/fmap_reader.sv
// Feature-map reader: fetches packed words from BRAM regions A/B and streams bytes in lockstep.
// Optional build macro FMAP_READER_RELU_EN zeroes negative output bytes.
module fmap_reader
   import fmap_reader_pkg::*;
#(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned RD_LAT = 1
) (
   input logic          clk,
   input logic          rst,
   fmap_reader_if.slave bus
);
   localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   fr_state_e         r_state;
   logic [ADDR_W-1:0] r_addr_a;
   logic [ADDR_W-1:0] r_addr_b;
   logic [CNT_W-1:0]  r_words_left;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic [IDX_W-1:0]  r_byte_idx;
   logic              r_en;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;
   logic              w_load;
   logic              w_shift;
   logic [BYTE_W-1:0] w_raw_a;
   logic [BYTE_W-1:0] w_raw_b;

   assign w_load  = (r_state == FR_WAIT) && (r_lat_cnt == '0);
   assign w_shift = r_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= FR_IDLE;
         r_addr_a     <= '0;
         r_addr_b     <= '0;
         r_words_left <= '0;
         r_lat_cnt    <= '0;
         r_byte_idx   <= '0;
         r_en         <= 1'b0;
         r_valid      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         case (r_state)
            FR_IDLE: begin
               if (bus.start) begin
                  r_addr_a     <= bus.base_addr_1;
                  r_addr_b     <= bus.base_addr_2;
                  r_words_left <= bus.word_cnt;
                  r_busy       <= 1'b1;
                  if (bus.word_cnt == '0) begin
                     r_state <= FR_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= FR_REQ;
                     r_en    <= 1'b1;
                  end
               end
            end
            FR_REQ: begin
               r_en      <= 1'b0;
               r_lat_cnt <= LAT_W'(RD_LAT - 1);
               r_state   <= FR_WAIT;
            end
            FR_WAIT: begin
               if (r_lat_cnt != '0) begin
                  r_lat_cnt <= r_lat_cnt - 1'b1;
               end else begin
                  r_byte_idx   <= '0;
                  r_words_left <= r_words_left - 1'b1;
                  r_valid      <= 1'b1;
                  r_state      <= FR_EMIT;
               end
            end
            FR_EMIT: begin
               if (w_shift) begin
                  r_byte_idx <= r_byte_idx + 1'b1;
                  if (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
                     r_valid <= 1'b0;
                     if (r_words_left == '0) begin
                        r_state <= FR_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        // Addresses wrap naturally at 2^ADDR_W.
                        r_addr_a <= r_addr_a + 1'b1;
                        r_addr_b <= r_addr_b + 1'b1;
                        r_en     <= 1'b1;
                        r_state  <= FR_REQ;
                     end
                  end
               end
            end
            FR_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= FR_IDLE;
            end
            default: r_state <= FR_IDLE;
         endcase
      end
   end

   fmap_unpack_lane #(.DATA_W(DATA_W)) u_lane_a (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (bus.dout_BRAM32k_1),
      .o_byte  (w_raw_a)
   );

   fmap_unpack_lane #(.DATA_W(DATA_W)) u_lane_b (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (bus.dout_BRAM32k_2),
      .o_byte  (w_raw_b)
   );

`ifdef FMAP_READER_RELU_EN
   assign bus.byte_a = fr_relu(w_raw_a);
   assign bus.byte_b = fr_relu(w_raw_b);
`else
   assign bus.byte_a = w_raw_a;
   assign bus.byte_b = w_raw_b;
`endif

   assign bus.en_BRAM32k     = r_en;
   assign bus.addr_BRAM32k_1 = r_addr_a;
   assign bus.addr_BRAM32k_2 = r_addr_b;
   assign bus.out_valid      = r_valid;
   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
endmodule

// File: tb/tb_fmap_reader.sv
// Bench for fmap_reader: BRAM model, queue-based reference of expected bytes/addresses,
// per-cycle compare process and directed bursts. Honours FMAP_READER_RELU_EN.
module tb_fmap_reader;
   import fmap_reader_pkg::*;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned RD_LAT = 1;
   localparam int          DEPTH  = 4096;

   logic clk;
   logic rst;

   fmap_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   fmap_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [63:0] mem [DEPTH];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0]  exp_a[$];
   logic [7:0]  exp_b[$];
   int          exp_addr_a[$];
   int          exp_addr_b[$];
   logic [7:0]  log_a[$];
   logic [7:0]  log_b[$];
   int          addr_log_a[$];
   int en_count, hs_count, done_count;
   int first_en_cyc, first_valid_cyc, done_cyc, last_hs_cyc, start_cyc;
   int bp_mode = 0;
   int bp_ph   = 0;
   logic       hold_pending = 1'b0;
   logic [7:0] held_a, held_b;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: byte k of a word is the k-th byte emitted, most significant first.
   function automatic logic [7:0] model_byte(input logic [63:0] w, input int k);
      logic [7:0] b;
      b = 8'((w >> (8 * (7 - k))) & 64'hFF);
`ifdef FMAP_READER_RELU_EN
      if ($signed(b) < 0) b = 8'h00;
`endif
      return b;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   always @(posedge clk) begin
      if (bus.en_BRAM32k) begin
         bus.dout_BRAM32k_1 <= mem[bus.addr_BRAM32k_1];
         bus.dout_BRAM32k_2 <= mem[bus.addr_BRAM32k_2];
      end
   end

   // Consumer ready: always 1, or the repeating pattern 1,0,0.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode != 0) begin
            bus.out_ready = (bp_ph == 0);
            bp_ph = (bp_ph + 1) % 3;
         end else begin
            bus.out_ready = 1'b1;
            bp_ph = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         hold_pending = 1'b0;
      end else begin
         if (bus.en_BRAM32k) begin
            en_count++;
            if (first_en_cyc < 0) first_en_cyc = cyc;
            addr_log_a.push_back(int'(bus.addr_BRAM32k_1));
            if (exp_addr_a.size() == 0) begin
               check("unexpected_en", 1, 0);
            end else begin
               check("addr_a", bus.addr_BRAM32k_1, 64'(exp_addr_a.pop_front()));
               check("addr_b", bus.addr_BRAM32k_2, 64'(exp_addr_b.pop_front()));
            end
         end
         if (hold_pending) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_a", bus.byte_a, held_a);
            check("hold_b", bus.byte_b, held_b);
         end
         hold_pending = 1'b0;
         if (bus.out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_ready) begin
               hs_count++;
               last_hs_cyc = cyc;
               log_a.push_back(bus.byte_a);
               log_b.push_back(bus.byte_b);
               if (exp_a.size() == 0) begin
                  check("unexpected_handshake", 1, 0);
               end else begin
                  check("byte_a", bus.byte_a, exp_a.pop_front());
                  check("byte_b", bus.byte_b, exp_b.pop_front());
               end
            end else begin
               hold_pending = 1'b1;
               held_a = bus.byte_a;
               held_b = bus.byte_b;
            end
         end
         if (bus.done) begin
            done_count++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check_all_zero(input string name);
      check({name, "_en"}, bus.en_BRAM32k, 0);
      check({name, "_addr1"}, bus.addr_BRAM32k_1, 0);
      check({name, "_addr2"}, bus.addr_BRAM32k_2, 0);
      check({name, "_valid"}, bus.out_valid, 0);
      check({name, "_byte_a"}, bus.byte_a, 0);
      check({name, "_byte_b"}, bus.byte_b, 0);
      check({name, "_busy"}, bus.busy, 0);
      check({name, "_done"}, bus.done, 0);
   endtask

   task automatic clear_model();
      exp_a.delete(); exp_b.delete(); exp_addr_a.delete(); exp_addr_b.delete();
      log_a.delete(); log_b.delete(); addr_log_a.delete();
      en_count = 0; hs_count = 0; done_count = 0;
      first_en_cyc = -1; first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
   endtask

   task automatic arm(input int a, input int b, input int cnt);
      clear_model();
      for (int w = 0; w < cnt; w++) begin
         exp_addr_a.push_back((a + w) % DEPTH);
         exp_addr_b.push_back((b + w) % DEPTH);
         for (int k = 0; k < 8; k++) begin
            exp_a.push_back(model_byte(mem[(a + w) % DEPTH], k));
            exp_b.push_back(model_byte(mem[(b + w) % DEPTH], k));
         end
      end
   endtask

   task automatic pulse_start(input int a, input int b, input int cnt);
      @(posedge clk);
      #1;
      bus.base_addr_1 = ADDR_W'(a);
      bus.base_addr_2 = ADDR_W'(b);
      bus.word_cnt    = CNT_W'(cnt);
      bus.start       = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic run_burst(input int a, input int b, input int cnt, input int bp, input int intrude);
      logic got;
      arm(a, b, cnt);
      bp_mode = bp;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      bus.base_addr_1 = ADDR_W'(a);
      bus.base_addr_2 = ADDR_W'(b);
      bus.word_cnt    = CNT_W'(cnt);
      bus.start       = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (intrude != 0) begin
         repeat (4) @(posedge clk);
         check("busy_before_intrude", bus.busy, 1);
         pulse_start(50, 60, 5);
      end
      got = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         #1;
         if (done_count != 0) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", got, 1);
      repeat (2) @(negedge clk);
      #1;
      bp_mode = 0;
      check("done_count", done_count, 1);
      check("en_count", en_count, cnt);
      check("hs_count", hs_count, 8 * cnt);
      check("exp_left", exp_a.size(), 0);
      check("busy_after", bus.busy, 0);
   endtask

   task automatic check_log(input string name, input int lane, input logic [63:0] lit);
      for (int k = 0; k < 8; k++) begin
         if (((lane == 0) ? log_a.size() : log_b.size()) <= k) begin
            check({name, "_missing"}, 1, 0);
         end else begin
            check(name, (lane == 0) ? log_a[k] : log_b[k], lit[63 - 8 * k -: 8]);
         end
      end
   endtask

   initial begin
      logic got;
      logic [63:0] lit_b;
      logic [63:0] lit_relu;
      rst = 1'b0;
      bus.start = 1'b0;
      bus.base_addr_1 = '0;
      bus.base_addr_2 = '0;
      bus.word_cnt = '0;
      bus.dout_BRAM32k_1 = '0;
      bus.dout_BRAM32k_2 = '0;
      clear_model();
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = {32'(i) * 32'h9E3779B1, (32'(i) * 32'h85EBCA6B) ^ 32'hDEADBEEF};
      end
      mem[REGION_A_BASE]     = 64'h0102030405060708;
      mem[REGION_B_BASE]     = 64'hF0E1D2C3B4A59687;
      mem[1]   = 64'h1112131415161718;
      mem[2]   = 64'h2122232425262728;
      mem[500] = 64'h7F80FF0001FE8100;
      mem[501] = 64'h80017F00FFC0407F;

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;

      // Basic single-word burst with exact latencies.
      run_burst(REGION_A_BASE, REGION_B_BASE, 1, 0, 0);
      check("en_latency", first_en_cyc - start_cyc, 1);
      check("valid_latency", first_valid_cyc - start_cyc, 3);
      check("done_after_last_hs", done_cyc - last_hs_cyc, 1);
      check_log("basic_a", 0, 64'h0102030405060708);
`ifdef FMAP_READER_RELU_EN
      lit_b = 64'h0000000000000000;
`else
      lit_b = 64'hF0E1D2C3B4A59687;
`endif
      check_log("basic_b", 1, lit_b);

      // Three words, with a stray start mid-burst that must be ignored.
      run_burst(REGION_A_BASE, REGION_B_BASE, 3, 0, 1);

      // Backpressure 1,0,0 on a two-word burst.
      run_burst(10, 300, 2, 1, 0);

      // Zero-length burst: done soon after start, no BRAM access.
      run_burst(5, 6, 0, 0, 0);
      check("zero_done_lat", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);

      // Address wrap at the top of the BRAM.
      run_burst(4095, 200, 2, 0, 0);
      check("wrap_addr0", addr_log_a.size() > 1 ? addr_log_a[1] : -1, 0);

      // Reset in the middle of EMIT, then a clean rerun.
      arm(REGION_A_BASE, REGION_B_BASE, 1);
      pulse_start(REGION_A_BASE, REGION_B_BASE, 1);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (hs_count >= 3) begin
            got = 1'b1;
            break;
         end
      end
      check("reach_byte3", got, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      run_burst(REGION_A_BASE, REGION_B_BASE, 1, 0, 0);
      check_log("after_reset_a", 0, 64'h0102030405060708);

      // Sign-mixed word: raw or clamped depending on the build.
      run_burst(500, 501, 1, 0, 0);
`ifdef FMAP_READER_RELU_EN
      lit_relu = 64'h7F00000001000000;
`else
      lit_relu = 64'h7F80FF0001FE8100;
`endif
      check_log("signed_a", 0, lit_relu);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
